// File: rtl/tspi_target.sv
// SPI mode-0 target serving reads and writes from a local byte memory.
// All SPI inputs are oversampled and edge-detected in the clk_i domain.
module tspi_target #(
    parameter int AddrWidth = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tspi_clk_i,
    input  logic                 tspi_cs_ni,
    input  logic                 tspi_mosi_i,
    output logic                 tspi_miso_o,
    input  logic [AddrWidth-1:0] bd_addr_i,
    output logic [7:0]           bd_rdata_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 err_o
);
    localparam int Depth = 2 ** AddrWidth;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        DISCARD
    } state_t;

    state_t state_q, state_d;

    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2;

    logic [4:0]           bit_cnt_q;
    logic [6:0]           rx_q;
    logic [7:0]           cmd_q;
    logic [7:0]           tx_q;
    logic [7:0]           rd_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 fetch_q;

    logic [7:0] mem [Depth];

    // Sync flops reset low so a CS already low at reset release shows no edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {sck_s1, sck_s2, sck_s3} <= '0;
            {cs_s1, cs_s2, cs_s3}    <= '0;
            {mosi_s1, mosi_s2}       <= '0;
        end else begin
            sck_s1  <= tspi_clk_i;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= tspi_cs_ni;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= tspi_mosi_i;
            mosi_s2 <= mosi_s1;
        end
    end

    logic                 rise, fall, cs_fall, byte_end;
    logic                 cmd_end, addr_end, cmd_bad;
    logic                 mem_we, rd_en;
    logic [7:0]           rx_byte;
    logic [AddrWidth-1:0] addr_shift, addr_inc, rd_addr;

    assign rise       = sck_s2 & ~sck_s3;
    assign fall       = ~sck_s2 & sck_s3;
    assign cs_fall    = cs_s3 & ~cs_s2;
    assign rx_byte    = {rx_q, mosi_s2};
    assign addr_shift = {addr_q[AddrWidth-2:0], mosi_s2};
    assign addr_inc   = addr_q + AddrWidth'(1);
    assign byte_end   = rise && (bit_cnt_q[2:0] == 3'd7);
    assign cmd_end    = (state_q == CMD) && byte_end;
    assign addr_end   = (state_q == ADDR) && rise && (bit_cnt_q == 5'd23);
    assign cmd_bad    = (rx_byte != 8'h02) && (rx_byte != 8'h03);
    assign mem_we     = !cs_s2 && (state_q == WR_DATA) && byte_end;
    assign rd_en      = !cs_s2 && ((addr_end && state_d == RD_DATA)
                        || (state_q == RD_DATA && byte_end));
    assign rd_addr    = (state_q == ADDR) ? addr_shift : addr_inc;
    assign busy_o     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        if (cs_s2) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (cs_fall) state_d = CMD;
                CMD:     if (cmd_end) state_d = ADDR;
                ADDR: begin
                    if (addr_end) begin
                        unique case (1'b1)
                            (cmd_q == 8'h03): state_d = RD_DATA;
                            (cmd_q == 8'h02): state_d = WR_DATA;
                            default:          state_d = DISCARD;
                        endcase
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            cmd_q        <= '0;
            tx_q         <= '0;
            addr_q       <= '0;
            fetch_q      <= 1'b0;
            tspi_miso_o  <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_o <= cs_s2 && (state_q != IDLE);
            err_o        <= !cs_s2 && cmd_end && cmd_bad;
            fetch_q      <= rd_en;
            if (rise) rx_q <= rx_byte[6:0];
            if (!cs_s2) begin
                if (state_q == IDLE && cs_fall) bit_cnt_q <= '0;
                if (rise && (state_q == CMD || state_q == ADDR)) begin
                    bit_cnt_q <= (cmd_end || addr_end) ? 5'd0 : bit_cnt_q + 5'd1;
                end
                if (rise && (state_q == RD_DATA || state_q == WR_DATA)) begin
                    bit_cnt_q <= {2'b00, bit_cnt_q[2:0] + 3'd1};
                end
                if (cmd_end) cmd_q <= rx_byte;
                if (rise && state_q == ADDR) addr_q <= addr_shift;
                if (byte_end && (state_q == RD_DATA || state_q == WR_DATA)) begin
                    addr_q <= addr_inc;
                end
            end
            if (fetch_q) begin
                tx_q <= rd_q;
            end else if (fall && state_q == RD_DATA) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
            if (cs_s2 || state_q != RD_DATA) begin
                tspi_miso_o <= 1'b0;
            end else if (fall) begin
                tspi_miso_o <= tx_q[7];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[addr_q] <= rx_byte;
        if (rd_en)  rd_q <= mem[rd_addr];
    end

    // Backdoor port sees pre-write contents on a same-cycle collision
    always_ff @(posedge clk_i) begin
        if (rst_i) bd_rdata_o <= '0;
        else       bd_rdata_o <= mem[bd_addr_i];
    end
endmodule

// File: tb/tb_tspi_target.sv
// Directed bench for tspi_target: SPI frames driven from one initial block,
// expected memory/MISO bytes queued in a scoreboard and popped on compare.
module tb_tspi_target;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] bd_addr = '0;
    logic [7:0] bd_rdata;
    logic       busy, done, err;

    always #5 clk = ~clk;

    tspi_target #(.AddrWidth(10)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tspi_clk_i   (sck),
        .tspi_cs_ni   (cs_n),
        .tspi_mosi_i  (mosi),
        .tspi_miso_o  (miso),
        .bd_addr_i    (bd_addr),
        .bd_rdata_o   (bd_rdata),
        .busy_o       (busy),
        .frame_done_o (done),
        .err_o        (err)
    );

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;

    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         miso_hi = 0;
    logic       watch = 1'b0;
    logic [7:0] model [1024];
    wr_t        bd_q [$];
    logic [7:0] rd_q [$];

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (watch && miso) miso_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            wait_n(8);
            sck = 1'b1;
            r[i] = miso;
            wait_n(8);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_n(8);
    endtask

    task automatic frame_end();
        wait_n(8);
        cs_n = 1'b1;
        wait_n(10);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] r;
        spi_byte(cmd, r);
        spi_byte(a[23:16], r);
        spi_byte(a[15:8], r);
        spi_byte(a[7:0], r);
    endtask

    task automatic write_frame(input logic [9:0] a, input logic [7:0] d0,
                               input logic [7:0] d1);
        logic [7:0] r;
        logic [9:0] a1;
        a1 = a + 10'd1;
        frame_start();
        send_hdr(8'h02, {14'd0, a});
        spi_byte(d0, r);
        spi_byte(d1, r);
        frame_end();
        model[a]  = d0;
        model[a1] = d1;
        bd_q.push_back('{a: a, d: d0});
        bd_q.push_back('{a: a1, d: d1});
    endtask

    task automatic bd_drain(input string tag);
        wr_t e;
        while (bd_q.size() > 0) begin
            e = bd_q.pop_front();
            bd_addr = e.a;
            wait_n(1);
            check(tag, {24'd0, bd_rdata}, {24'd0, e.d});
        end
    endtask

    task automatic read_frame(input string tag, input logic [9:0] a);
        logic [7:0] r;
        logic [9:0] a1;
        a1 = a + 10'd1;
        rd_q.push_back(model[a]);
        rd_q.push_back(model[a1]);
        frame_start();
        send_hdr(8'h03, {14'd0, a});
        for (int k = 0; k < 2; k++) begin
            spi_byte(8'h00, r);
            if (rd_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
            else check(tag, {24'd0, r}, {24'd0, rd_q.pop_front()});
        end
        frame_end();
    endtask

    initial begin
        logic [7:0] r;
        int         d0, e0;

        wait_n(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_bd", {24'd0, bd_rdata}, 32'd0);
        rst = 1'b0;
        wait_n(4);

        d0 = done_cnt;
        cs_n = 1'b0;
        wait_n(8);
        check("busy_frame", {31'd0, busy}, 32'd1);
        cs_n = 1'b1;
        wait_n(10);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("done_empty", done_cnt - d0, 32'd1);

        d0 = done_cnt;
        write_frame(10'h010, 8'hA5, 8'h3C);
        check("wr_done", done_cnt - d0, 32'd1);
        bd_drain("wr_bd");

        read_frame("rd_miso", 10'h010);

        write_frame(10'h3FF, 8'h11, 8'h22);
        bd_drain("wrap_bd");
        read_frame("wrap_miso", 10'h3FF);

        write_frame(10'h020, 8'h5A, 8'h6B);
        bd_drain("pre_abort_bd");
        d0 = done_cnt;
        frame_start();
        send_hdr(8'h02, 24'h000020);
        spi_bits(8'hFF, 4, r);
        frame_end();
        check("abort_done", done_cnt - d0, 32'd1);
        bd_q.push_back('{a: 10'h020, d: model[10'h020]});
        bd_q.push_back('{a: 10'h021, d: model[10'h021]});
        bd_drain("abort_bd");
        write_frame(10'h020, 8'hC3, 8'h96);
        bd_drain("post_abort_bd");

        e0 = err_cnt;
        d0 = done_cnt;
        miso_hi = 0;
        watch = 1'b1;
        frame_start();
        send_hdr(8'h9F, 24'h000010);
        spi_byte(8'hFF, r);
        frame_end();
        watch = 1'b0;
        check("bad_err", err_cnt - e0, 32'd1);
        check("bad_miso", miso_hi, 32'd0);
        check("bad_done", done_cnt - d0, 32'd1);
        bd_q.push_back('{a: 10'h010, d: model[10'h010]});
        bd_q.push_back('{a: 10'h011, d: model[10'h011]});
        bd_drain("bad_bd");

        frame_start();
        send_hdr(8'h03, 24'h000010);
        spi_bits(8'h00, 4, r);
        rst = 1'b1;
        wait_n(1);
        check("mid_rst_miso", {31'd0, miso}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_bd", {24'd0, bd_rdata}, 32'd0);
        rst = 1'b0;
        miso_hi = 0;
        watch = 1'b1;
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        watch = 1'b0;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_miso", miso_hi, 32'd0);
        cs_n = 1'b1;
        wait_n(10);
        read_frame("post_rst_rd", 10'h010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
